shift_feed_ctrl: RTL

SHIFT_FEED_CTRL -- requirements
Module: shift_feed_ctrl

---
 rtl/shift_feed_pkg.sv | 26 ++
 rtl/shift_feed_fifo.sv | 65 ++++++
 rtl/shift_feed_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/shift_feed_pkg.sv
// shift_feed_pkg -- shared constants and state encoding for the serial feed controller.
// Revision 1.0
`default_nettype none

package shift_feed_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Downstream shift-register mode encodings; 2'b11 is never produced.
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [1:0] dir_mode(input logic dir);
    return dir ? SHL : SHR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_feed_fifo.sv
// shift_feed_fifo -- small circular FIFO with occupancy count and flush.
// Revision 1.0
`default_nettype none

module shift_feed_fifo
  import shift_feed_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [LW-1:0]    level_q;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

`default_nettype wire

// File: rtl/shift_feed_ctrl.sv
// shift_feed_ctrl -- buffers bytes and serialises each one into a downstream
// shift register, LSB-first for shift-right or MSB-first for shift-left.
// Revision 1.0
`default_nettype none

module shift_feed_ctrl
  import shift_feed_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       Re,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       dir,
  input  logic                       flush,
  output logic                       sIn,
  output logic [1:0]                 mode,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic             sin_q, sin_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             push;
  logic             pop;
  logic             load;
  logic [WIDTH-1:0] fifo_head;
  logic [CW-1:0]    idx_d;

  assign in_ready = (level < LW'(DEPTH)) && !flush && !Re;
  assign push     = in_valid && in_ready;

  shift_feed_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (Re),
    .flush_i     (flush),
    .push_i      (push),
    .push_data_i (in_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .level_o     (level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    load    = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          load = (level != '0);
        end
        ST_SHIFT: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (level != '0) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Direction is captured with the byte so later dir changes cannot corrupt it.
      if (load) begin
        data_d  = fifo_head;
        dir_d   = dir;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
    end

    pop = load;

    // Outputs are registered from next-state so they carry no input-to-output path.
    idx_d  = dir_d ? (CW'(WIDTH - 1) - cnt_d) : cnt_d;
    sin_d  = (state_d == ST_SHIFT) && data_d[idx_d];
    mode_d = (state_d == ST_SHIFT) ? dir_mode(dir_d) : HOLD;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (Re) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      sin_q   <= 1'b0;
      mode_q  <= HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      sin_q   <= sin_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign sIn  = sin_q;
  assign mode = mode_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire
